// File: rtl/tetris_input_conditioner.sv
// Purpose: turns three raw, bouncing push-buttons into clean one-cycle command
// pulses for the tetris core. Each button is synchronised (2 flops), debounced
// and edge-detected. Left/right additionally auto-repeat while held; rotate
// fires once per press. A simultaneous left+right press is rejected until both
// buttons are released.
// Ports:
//   CLK        - system clock, rising edge
//   CLR        - synchronous active-low reset
//   btn_right  - raw right button (async, active-high)
//   btn_left   - raw left button (async, active-high)
//   btn_rotate - raw rotate button (async, active-high)
//   right      - one-cycle move-right pulse (registered)
//   left       - one-cycle move-left pulse (registered)
//   rotating   - one-cycle rotate pulse (registered)
//   dbg_state  - lateral FSM state: 0 IDLE, 1 DELAY, 2 REPEAT, 3 BLOCK
module tetris_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_RATE     = 8,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_rotate,
  output logic       right,
  output logic       left,
  output logic       rotating,
  output logic [1:0] dbg_state
);

  localparam int unsigned NBTN    = 3;
  localparam int unsigned B_RIGHT = 0;
  localparam int unsigned B_LEFT  = 1;
  localparam int unsigned B_ROT   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_BLOCK  = 2'd3
  } state_t;

  logic [NBTN-1:0]  w_raw;
  logic [NBTN-1:0]  r_sync1;
  logic [NBTN-1:0]  r_sync2;
  logic [NBTN-1:0]  r_deb;
  logic [NBTN-1:0]  r_deb_q;
  logic [NBTN-1:0]  w_rise;
  logic [CNT_W-1:0] r_db_cnt [NBTN];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic [CNT_W-1:0] w_rep_cnt_nxt;
  logic             r_dir;          // active lateral direction: 0 right, 1 left
  logic             w_dir_nxt;
  logic             w_right_nxt;
  logic             w_left_nxt;
  logic             w_act_held;
  logic             w_opp_held;
  logic             r_right;
  logic             r_left;
  logic             r_rot;

  assign w_raw  = {btn_rotate, btn_left, btn_right};
  assign w_rise = r_deb & ~r_deb_q;

  // Synchroniser, debounce counters and debounced-level history
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      for (int unsigned i = 0; i < NBTN; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      for (int unsigned i = 0; i < NBTN; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // this cycle is the DEBOUNCE_CYCLES-th consecutive disagreement
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Lateral FSM: next state, repeat counter and pulse requests
  always_comb begin
    w_state_nxt   = r_state;
    w_rep_cnt_nxt = r_rep_cnt;
    w_dir_nxt     = r_dir;
    w_right_nxt   = 1'b0;
    w_left_nxt    = 1'b0;
    w_act_held    = r_dir ? r_deb[B_LEFT]  : r_deb[B_RIGHT];
    w_opp_held    = r_dir ? r_deb[B_RIGHT] : r_deb[B_LEFT];
    case (r_state)
      ST_IDLE: begin
        if (w_rise[B_RIGHT] && w_rise[B_LEFT]) begin
          w_state_nxt = ST_BLOCK;
        end else if (w_rise[B_RIGHT] || w_rise[B_LEFT]) begin
          w_dir_nxt     = w_rise[B_LEFT];
          w_right_nxt   = w_rise[B_RIGHT];
          w_left_nxt    = w_rise[B_LEFT];
          w_rep_cnt_nxt = CNT_W'(REPEAT_DELAY);
          w_state_nxt   = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        // opposite press wins over a same-cycle release: both end the burst
        if (w_opp_held) begin
          w_state_nxt = ST_BLOCK;
        end else if (!w_act_held) begin
          w_state_nxt = ST_IDLE;
        end else if (r_rep_cnt == CNT_W'(1)) begin
          w_right_nxt   = !r_dir;
          w_left_nxt    = r_dir;
          w_rep_cnt_nxt = CNT_W'(REPEAT_RATE);
          w_state_nxt   = ST_REPEAT;
        end else begin
          w_rep_cnt_nxt = r_rep_cnt - CNT_W'(1);
        end
      end
      ST_BLOCK: begin
        if (!r_deb[B_RIGHT] && !r_deb[B_LEFT]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state   <= ST_IDLE;
      r_rep_cnt <= '0;
      r_dir     <= 1'b0;
      r_right   <= 1'b0;
      r_left    <= 1'b0;
      r_rot     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rep_cnt <= w_rep_cnt_nxt;
      r_dir     <= w_dir_nxt;
      r_right   <= w_right_nxt;
      r_left    <= w_left_nxt;
      r_rot     <= w_rise[B_ROT];
    end
  end

  assign right     = r_right;
  assign left      = r_left;
  assign rotating  = r_rot;
  assign dbg_state = r_state;

endmodule

// File: doc/tetris_input_conditioner.md
Name: tetris_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the tetris game core.
- Converts three raw, asynchronous, bouncing push-buttons into clean single-CLK command pulses on right, left and rotating. These pulses drive the core's same-named inputs.
- Functions: 2-flop synchronisation, per-button debounce, rising-edge detection, and auto-repeat for the lateral moves.
- Rotation never repeats. A simultaneous left+right press is rejected.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable sampled cycles before the debounced level changes (>=1)
REPEAT_DELAY, 16, cycles from the first lateral pulse to the first repeat pulse (>=2)
REPEAT_RATE, 8, cycles between subsequent repeat pulses (>=2)
CNT_W, 16, width of the debounce and repeat counters; must hold the largest of the three parameters

Ports:
CLK  input  1  system clock; all logic on the rising edge
CLR  input  1  synchronous, active-low reset
btn_right  input  1  raw right button, asynchronous, active-high
btn_left  input  1  raw left button, asynchronous, active-high
btn_rotate  input  1  raw rotate button, asynchronous, active-high
right  output  1  one-CLK move-right pulse to the game core
left  output  1  one-CLK move-left pulse to the game core
rotating  output  1  one-CLK rotate pulse to the game core
dbg_state  output  2  lateral FSM state: 0 IDLE, 1 DELAY, 2 REPEAT, 3 BLOCK

Behaviour:
- Reset
  - Clock and reset: one clock CLK; reset CLR is synchronous and active-low.
  - CLR=0 at an edge clears all of the following: sync flops, debounced levels, counters, the FSM (to IDLE) and all outputs.
  - After that edge, right, left and rotating are 0 and dbg_state is 0.
  - Reset mid-repeat aborts immediately, with no trailing pulse.
  - A button still held when reset releases is treated as a new press.
- Synchroniser
  - Each button passes through two flops, giving sN.
- Debounce (per button)
  - Each button has a counter and a debounced level dN.
  - If sN != dN, the counter increments. When it reaches DEBOUNCE_CYCLES, dN takes sN and the counter clears.
  - If sN == dN, the counter clears. Any glitch therefore restarts the count.
- Timing reference
  - Raw input stable from before edge 0 gives: sN valid after edge 1, and dN flips at edge 1+DEBOUNCE_CYCLES.
  - The command pulse is registered at edge 2+DEBOUNCE_CYCLES and deasserts at the next edge.
- Rotate
  - rotating = 1 for exactly one cycle on each dN rising edge. Holding the button gives no further pulses.
- Lateral FSM (shared by left and right)
  - IDLE:
    - On a rising edge of exactly one of dR/dL: pulse that direction, load the repeat counter with REPEAT_DELAY, and go to DELAY.
    - If both rise in the same cycle: go to BLOCK with no pulse.
  - DELAY:
    - Counter decrements each cycle while the same direction stays held.
    - When the counter hits 1: pulse, load REPEAT_RATE, and go to REPEAT.
  - REPEAT:
    - Same as DELAY, but reloads REPEAT_RATE on every pulse.
    - Pulses occur at P, P+REPEAT_DELAY, P+REPEAT_DELAY+REPEAT_RATE, and so on.
  - Leaving DELAY or REPEAT:
    - Active direction released: go to IDLE with no pulse in that cycle.
    - Opposite direction becomes held: go to BLOCK with no pulse.
  - BLOCK:
    - No lateral pulses. Stays in BLOCK until dR=0 and dL=0, then goes to IDLE.
    - A still-held single button does not fire; it must be released and re-pressed.
- Outputs
  - All outputs are registered.
  - right and left are never both 1.
  - rotating is independent and may coincide with a lateral pulse.

Test Plan:
Defaults DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8; edge 0 is the first edge with the raw input high.
- Reset: CLR=0 for 3 edges with all buttons toggling -> right=left=rotating=0 and dbg_state=0 throughout and one edge after CLR rises.
- Bounce: btn_right toggles every 2 cycles for 12 cycles, then stays high for 10 cycles and is released -> exactly one right pulse, 6 edges after the final rise; left=0.
- Auto-repeat: btn_right high for edges 0..59, then low -> right pulses at edges 6, 22, 30, 38, 46, 54, 62 (7 pulses); none after the debounced release at edge 65; dbg_state shows 1 then 2 then 0.
- Rotate hold: btn_rotate high for 40 cycles -> single rotating pulse at edge 6; no repeat.
- Conflict: btn_left and btn_right rise together and are held 30 cycles -> no pulses, dbg_state=3. Release right only -> still no pulse. Release left, then re-press left -> left pulse 6 edges after the re-press.
- Reset mid-repeat: btn_left held, CLR=0 at edge 25 for one edge -> no pulse in that cycle and dbg_state=0. Left still held -> new left pulse 6 edges after CLR returns high.
